sample_dispatcher: RTL

Shares the single ADC sample stream between the NCORES processing cores of the multicore array. Incoming samples are buffered in a small FIFO. Each buffered sample is handed to exactly one requesting core, chosen by round-robin arbitration. The block sits between the ADC sample source and the per-core input request lines, and replaces the "any core requests, read next sample" broadcast scheme.

---
 rtl/dispatch_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/sample_dispatcher.sv | 116 +++++++++++
 3 files changed

// File: rtl/dispatch_pkg.sv
// dispatch_pkg
// Shared defaults and types for the ADC sample dispatcher.
//   NCORES_DEF : number of processing cores sharing the sample stream
//   DW_DEF     : sample width in bits
//   DEPTH_DEF  : sample FIFO depth (power of two)
//   sample_t   : signed ADC sample at the default width
//   idx_w()    : width of an index into n items, never less than 1
package dispatch_pkg;

  localparam int NCORES_DEF = 28;
  localparam int DW_DEF     = 31;
  localparam int DEPTH_DEF  = 4;

  typedef logic signed [DW_DEF-1:0] sample_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter
// Combinational round-robin arbiter. Grants the first requesting index
// found by searching upward from last+1, wrapping past N-1 back to 0.
// Ports:
//   req  : request vector, one bit per requester
//   last : index granted most recently (search starts just above it)
//   gnt  : one-hot grant, zero when nothing requests
//   any  : at least one request is present
//   idx  : binary index of the granted requester
module rr_arbiter
  import dispatch_pkg::*;
#(
  parameter  int N  = NCORES_DEF,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic          any,
  output logic [IW-1:0] idx
);

  // Walk the candidates from farthest (last+N, i.e. last itself) to nearest
  // (last+1); each hit overwrites the previous one, so the nearest requester
  // after last is what remains at the end.
  always_comb begin
    int w_j;
    w_j = 0;
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = (int'(last) + k) % N;
      if (req[w_j]) begin
        gnt      = '0;
        gnt[w_j] = 1'b1;
        any      = 1'b1;
        idx      = IW'(w_j);
      end
    end
  end

endmodule

// File: rtl/sample_dispatcher.sv
// sample_dispatcher
// Buffers the ADC sample stream in a small FIFO and hands each sample to
// exactly one requesting core, chosen round-robin.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   s_data      : incoming ADC sample
//   s_valid     : s_data valid this cycle
//   s_ready     : FIFO not full; a push happens on s_valid && s_ready
//   req         : per-core sample request
//   core_data   : sample for the granted core (shared by all cores)
//   core_grant  : one-hot or zero; marks the owner of core_data this cycle
//   level       : FIFO occupancy
//   dispatched  : count of samples granted, wraps at 16 bits
module sample_dispatcher
  import dispatch_pkg::*;
#(
  parameter  int NCORES = NCORES_DEF,
  parameter  int DW     = DW_DEF,
  parameter  int DEPTH  = DEPTH_DEF,
  localparam int LW     = $clog2(DEPTH) + 1,
  localparam int IW     = idx_w(NCORES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     s_data,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [NCORES-1:0] req,
  output logic [DW-1:0]     core_data,
  output logic [NCORES-1:0] core_grant,
  output logic [LW-1:0]     level,
  output logic [15:0]       dispatched
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0]     r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;
  logic [IW-1:0]     r_last;
  logic [NCORES-1:0] r_grant;
  logic [DW-1:0]     r_data;
  logic [15:0]       r_dispatched;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [NCORES-1:0] w_elig;
  logic [NCORES-1:0] w_gnt;
  logic              w_any;
  logic [IW-1:0]     w_idx;

  // Readiness comes from the registered level only, so a pop in the same
  // cycle never opens a slot for a push while full.
  assign w_ready = (r_level != LW'(DEPTH));
  assign w_push  = s_valid && w_ready;

  // A core granted last cycle still shows its old request; mask it once.
  assign w_elig = req & ~r_grant;

  rr_arbiter #(.N(NCORES)) u_arb (
    .req  (w_elig),
    .last (r_last),
    .gnt  (w_gnt),
    .any  (w_any),
    .idx  (w_idx)
  );

  // Registered level: a sample pushed into an empty FIFO waits one cycle
  // before it can be arbitrated.
  assign w_pop = (r_level != '0) && w_any;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_last       <= IW'(NCORES - 1);
      r_grant      <= '0;
      r_data       <= '0;
      r_dispatched <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr     <= r_rd_ptr + PW'(1);
        r_grant      <= w_gnt;
        r_data       <= r_mem[r_rd_ptr];
        r_last       <= w_idx;
        r_dispatched <= r_dispatched + 16'd1;
      end else begin
        r_grant <= '0;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign s_ready    = w_ready;
  assign core_data  = r_data;
  assign core_grant = r_grant;
  assign level      = r_level;
  assign dispatched = r_dispatched;

endmodule
